// File: rtl/qlu_pkg.sv
// qlu_pkg: shared definitions for the Q-matrix write-back engine.
//   - qlu_state_t : engine FSM states
//   - SAT_MAX/MIN : clamp limits for a 32-bit signed Q value
//   - q_addr_pack : Q-memory address {state, action}
package qlu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_CALC = 3'd3,
        ST_WR   = 3'd4
    } qlu_state_t;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    // Widest state supported by the packing helper; callers zero-extend
    // their state into it and cast the result down to SW+2 bits.
    localparam int ADDR_SW_MAX = 16;

    function automatic logic [ADDR_SW_MAX+1:0] q_addr_pack(
        input logic [ADDR_SW_MAX-1:0] state,
        input logic [1:0]             action
    );
        return {state, action};
    endfunction

endpackage

// File: rtl/q_update_calc.sv
// q_update_calc: registered Q-learning update datapath.
//   Qnew = Qcur + ((R + ((gamma*maxQ) >>> 16) - Qcur) >>> ALPHA_SH)
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : load qnew/sat with the result of the current inputs
//   gamma     : unsigned 0.16 discount factor
//   maxq, r, qcur : signed QW-bit operands
//   qnew      : registered result, QW bits
//   sat       : registered flag, result was clamped
// Build option: QLU_SAT_EN clamps out-of-range results to SAT_MAX/SAT_MIN
// and raises sat; otherwise the result wraps and sat stays 0.
// The clamp constants are 32-bit, matching the QW=32 configuration.
module q_update_calc
    import qlu_pkg::*;
#(
    parameter int QW       = 32,
    parameter int ALPHA_SH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [15:0]   gamma,
    input  logic [QW-1:0] maxq,
    input  logic [QW-1:0] r,
    input  logic [QW-1:0] qcur,
    output logic [QW-1:0] qnew,
    output logic          sat
);

`ifdef QLU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic signed [47:0]   gamma_x;
    logic signed [47:0]   maxq_x;
    logic signed [47:0]   prod;
    logic signed [QW+1:0] gq;
    logic signed [QW+1:0] r_x;
    logic signed [QW+1:0] qcur_x;
    logic signed [QW+1:0] td;
    logic signed [QW+1:0] qnew_w;
    logic                 ovf;
    logic [QW-1:0]        q_res;

    // gamma < 1.0, so |gamma*maxQ| < 2^47 and the 48-bit product is exact.
    assign gamma_x = {32'd0, gamma};
    assign maxq_x  = {{(48-QW){maxq[QW-1]}}, maxq};
    assign prod    = gamma_x * maxq_x;
    assign gq      = (QW+2)'(prod >>> 16);

    // Two guard bits hold R + gq - Qcur without overflow.
    assign r_x    = {{2{r[QW-1]}}, r};
    assign qcur_x = {{2{qcur[QW-1]}}, qcur};
    assign td     = r_x + gq - qcur_x;
    assign qnew_w = qcur_x + (td >>> ALPHA_SH);

    // Out of QW range when the top three bits are not a pure sign extension.
    assign ovf = (qnew_w[QW+1:QW-1] != 3'b000) && (qnew_w[QW+1:QW-1] != 3'b111);

    always_comb begin
        q_res = qnew_w[QW-1:0];
        if (SAT_EN && ovf) begin
            q_res = qnew_w[QW+1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qnew <= '0;
            sat  <= 1'b0;
        end else if (en) begin
            qnew <= q_res;
            sat  <= SAT_EN && ovf;
        end
    end

endmodule

// File: rtl/q_update.sv
// q_update: Q-matrix write-back engine for the two-agent (A/B) core.
// Per accepted request, agent A then agent B: read Q(Snx,0..3) and Q(S,A),
// compute the update, write Q(S,A). learning=0 completes with no traffic.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   upd_valid/upd_ready      : request handshake (ready = idle)
//   learning, gamma          : sampled at accept
//   S_*, Snx_*, A_*, R_*     : per-agent state, next state, action, reward
//   q_sel, q_addr            : Q-matrix select (0=A, 1=B) and address
//   q_rd_en/q_rdata          : read strobe, data valid one cycle later
//   q_wr_en/q_wdata          : write strobe and data
//   upd_done                 : one-cycle completion pulse
//   sat_evt                  : clamp flag coincident with q_wr_en
// Build option: QLU_SAT_EN enables clamping in q_update_calc.
module q_update
    import qlu_pkg::*;
#(
    parameter int QW       = 32,
    parameter int FRAC     = 16,
    parameter int SW       = 12,
    parameter int ALPHA_SH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic          learning,
    input  logic [15:0]   gamma,
    input  logic [SW-1:0] S_A,
    input  logic [SW-1:0] Snx_A,
    input  logic [SW-1:0] S_B,
    input  logic [SW-1:0] Snx_B,
    input  logic [1:0]    A_A,
    input  logic [1:0]    A_B,
    input  logic [QW-1:0] R_A,
    input  logic [QW-1:0] R_B,
    output logic          q_sel,
    output logic [SW+1:0] q_addr,
    output logic          q_rd_en,
    input  logic [QW-1:0] q_rdata,
    output logic          q_wr_en,
    output logic [QW-1:0] q_wdata,
    output logic          upd_done,
    output logic          sat_evt
);

    qlu_state_t    state_reg, state_next;
    logic [2:0]    k_reg;
    logic          agent_reg;
    logic [15:0]   gamma_reg;
    logic [SW-1:0] s_reg   [2];
    logic [SW-1:0] snx_reg [2];
    logic [1:0]    a_reg   [2];
    logic [QW-1:0] r_reg   [2];
    logic [QW-1:0] maxq_reg;
    logic [QW-1:0] qcur_reg;
    logic          done_reg;
    logic          accept;
    logic          calc_en;
    logic [QW-1:0] calc_qnew;
    logic          calc_sat;
    logic [SW+1:0] addr_cur;
    logic [SW+1:0] addr_nxt;

    assign accept   = upd_valid && upd_ready;
    assign upd_done = done_reg;

    // Q-value format (FRAC fraction bits) is carried through unchanged:
    // gamma is 0.16, so the >>>16 after the multiply restores Q scaling.
    assign addr_cur = (SW+2)'(q_addr_pack(ADDR_SW_MAX'(s_reg[agent_reg]), a_reg[agent_reg]));
    assign addr_nxt = (SW+2)'(q_addr_pack(ADDR_SW_MAX'(snx_reg[agent_reg]), k_reg[1:0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        upd_ready  = 1'b0;
        q_sel      = 1'b0;
        q_addr     = '0;
        q_rd_en    = 1'b0;
        q_wr_en    = 1'b0;
        q_wdata    = '0;
        sat_evt    = 1'b0;
        calc_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                upd_ready = !rst;
                if (upd_valid && !rst && learning) begin
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                q_sel   = agent_reg;
                q_rd_en = 1'b1;
                q_addr  = (k_reg == 3'd4) ? addr_cur : addr_nxt;
                if (k_reg == 3'd4) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                q_sel      = agent_reg;
                state_next = ST_CALC;
            end
            ST_CALC: begin
                q_sel      = agent_reg;
                calc_en    = 1'b1;
                state_next = ST_WR;
            end
            ST_WR: begin
                q_sel      = agent_reg;
                q_wr_en    = 1'b1;
                q_addr     = addr_cur;
                q_wdata    = calc_qnew;
                sat_evt    = calc_sat;
                state_next = agent_reg ? ST_IDLE : ST_RD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg     <= '0;
            agent_reg <= 1'b0;
            gamma_reg <= '0;
            maxq_reg  <= '0;
            qcur_reg  <= '0;
            done_reg  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                s_reg[i]   <= '0;
                snx_reg[i] <= '0;
                a_reg[i]   <= '0;
                r_reg[i]   <= '0;
            end
        end else begin
            done_reg <= (accept && !learning) || (state_reg == ST_WR && agent_reg);

            if (accept) begin
                gamma_reg  <= gamma;
                s_reg[0]   <= S_A;
                snx_reg[0] <= Snx_A;
                a_reg[0]   <= A_A;
                r_reg[0]   <= R_A;
                s_reg[1]   <= S_B;
                snx_reg[1] <= Snx_B;
                a_reg[1]   <= A_B;
                r_reg[1]   <= R_B;
                agent_reg  <= 1'b0;
                k_reg      <= '0;
            end

            if (state_reg == ST_RD) begin
                k_reg <= (k_reg == 3'd4) ? 3'd0 : k_reg + 3'd1;
                // In slot k the data of read k-1 is on q_rdata; slots 1..4
                // carry the four next-state actions. Ties keep the first.
                if (k_reg != 3'd0) begin
                    if (k_reg == 3'd1 || $signed(q_rdata) > $signed(maxq_reg)) begin
                        maxq_reg <= q_rdata;
                    end
                end
            end

            if (state_reg == ST_WAIT) begin
                qcur_reg <= q_rdata;
            end

            if (state_reg == ST_WR && !agent_reg) begin
                agent_reg <= 1'b1;
            end
        end
    end

    q_update_calc #(
        .QW       (QW),
        .ALPHA_SH (ALPHA_SH)
    ) u_calc (
        .clk   (clk),
        .rst   (rst),
        .en    (calc_en),
        .gamma (gamma_reg),
        .maxq  (maxq_reg),
        .r     (r_reg[agent_reg]),
        .qcur  (qcur_reg),
        .qnew  (calc_qnew),
        .sat   (calc_sat)
    );

endmodule

// File: tb/tb_q_update.sv
// tb_q_update: directed-vector bench for q_update (ALPHA_SH=2).
// Provides a two-bank synchronous-read Q-memory model, records per-agent
// reads/writes and completion timing, and compares against hand-computed
// values. Expected saturation results follow QLU_SAT_EN.
module tb_q_update;

    localparam int QW = 32;
    localparam int SW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic          learning = 1'b0;
    logic [15:0]   gamma = '0;
    logic [SW-1:0] S_A = '0, Snx_A = '0, S_B = '0, Snx_B = '0;
    logic [1:0]    A_A = '0, A_B = '0;
    logic [QW-1:0] R_A = '0, R_B = '0;
    logic          q_sel;
    logic [SW+1:0] q_addr;
    logic          q_rd_en;
    logic [QW-1:0] q_rdata = '0;
    logic          q_wr_en;
    logic [QW-1:0] q_wdata;
    logic          upd_done;
    logic          sat_evt;

    always #5 clk = ~clk;

    q_update #(
        .QW       (QW),
        .FRAC     (16),
        .SW       (SW),
        .ALPHA_SH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .learning  (learning),
        .gamma     (gamma),
        .S_A       (S_A),
        .Snx_A     (Snx_A),
        .S_B       (S_B),
        .Snx_B     (Snx_B),
        .A_A       (A_A),
        .A_B       (A_B),
        .R_A       (R_A),
        .R_B       (R_B),
        .q_sel     (q_sel),
        .q_addr    (q_addr),
        .q_rd_en   (q_rd_en),
        .q_rdata   (q_rdata),
        .q_wr_en   (q_wr_en),
        .q_wdata   (q_wdata),
        .upd_done  (upd_done),
        .sat_evt   (sat_evt)
    );

    // Q-memory model: two banks, registered read
    logic [31:0] mem [0:1][0:16383];

    always @(posedge clk) begin
        if (q_rd_en) q_rdata <= mem[q_sel][q_addr];
        if (q_wr_en) mem[q_sel][q_addr] = q_wdata;
    end

    // Cycle bookkeeping: cycle 1 is the cycle right after the accept edge.
    int edge_cnt = 0;
    int t0 = 0;
    logic mon_on = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int rd_cnt [2];
    int wr_cnt [2];
    int wr_cyc [2];
    logic [31:0] wr_data [2];
    logic [31:0] wr_addr [2];
    logic [31:0] wr_sat  [2];
    int done_cnt, done_cyc, first_ready, ready_low;

    always @(negedge clk) begin
        if (mon_on) begin
            int rel;
            rel = edge_cnt - t0 + 1;
            if (q_rd_en) rd_cnt[q_sel] = rd_cnt[q_sel] + 1;
            if (q_wr_en) begin
                wr_cnt[q_sel]  = wr_cnt[q_sel] + 1;
                wr_cyc[q_sel]  = rel;
                wr_data[q_sel] = q_wdata;
                wr_addr[q_sel] = 32'(q_addr);
                wr_sat[q_sel]  = {31'd0, sat_evt};
            end
            if (upd_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = rel;
            end
            if (upd_ready && first_ready < 0) first_ready = rel;
            if (!upd_ready) ready_low = ready_low + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_q(input int sel, input int st, input int act, input logic [31:0] v);
        mem[sel][st*4 + act] = v;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            rd_cnt[i] = 0; wr_cnt[i] = 0; wr_cyc[i] = -1;
            wr_data[i] = '0; wr_addr[i] = '0; wr_sat[i] = '0;
        end
        done_cnt = 0; done_cyc = -1; first_ready = -1; ready_low = 0;
    endtask

    // Present one request at a negedge; it is accepted on the next edge.
    task automatic start_txn(input logic lrn, input logic [15:0] g,
                             input int sa, input int sna, input int aa, input logic [31:0] ra,
                             input int sb, input int snb, input int ab, input logic [31:0] rb);
        @(negedge clk);
        clear_mon();
        learning = lrn; gamma = g;
        S_A = SW'(sa); Snx_A = SW'(sna); A_A = 2'(aa); R_A = ra;
        S_B = SW'(sb); Snx_B = SW'(snb); A_B = 2'(ab); R_B = rb;
        upd_valid = 1'b1;
        check_eq("ready_before_accept", {31'd0, upd_ready}, 32'd1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        t0 = edge_cnt;
        mon_on = 1'b1;
    endtask

    task automatic run_txn(input string tag, input logic [15:0] g,
                           input int sa, input int sna, input int aa, input logic [31:0] ra,
                           input int sb, input int snb, input int ab, input logic [31:0] rb,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic [31:0] exp_sat_a, input logic [31:0] exp_sat_b);
        start_txn(1'b1, g, sa, sna, aa, ra, sb, snb, ab, rb);
        repeat (22) @(negedge clk);
        mon_on = 1'b0;
        $display("txn %s: A wr 0x%08h @%0d sat %0d, B wr 0x%08h @%0d sat %0d, done @%0d",
                 tag, wr_data[0], wr_cyc[0], wr_sat[0], wr_data[1], wr_cyc[1], wr_sat[1], done_cyc);
        check_eq({tag, "_rd_a"},    32'(rd_cnt[0]), 32'd5);
        check_eq({tag, "_rd_b"},    32'(rd_cnt[1]), 32'd5);
        check_eq({tag, "_wrn_a"},   32'(wr_cnt[0]), 32'd1);
        check_eq({tag, "_wrn_b"},   32'(wr_cnt[1]), 32'd1);
        check_eq({tag, "_wcyc_a"},  32'(wr_cyc[0]), 32'd8);
        check_eq({tag, "_wcyc_b"},  32'(wr_cyc[1]), 32'd16);
        check_eq({tag, "_waddr_a"}, wr_addr[0], 32'(sa*4 + aa));
        check_eq({tag, "_waddr_b"}, wr_addr[1], 32'(sb*4 + ab));
        check_eq({tag, "_wdata_a"}, wr_data[0], exp_a);
        check_eq({tag, "_wdata_b"}, wr_data[1], exp_b);
        check_eq({tag, "_sat_a"},   wr_sat[0], exp_sat_a);
        check_eq({tag, "_sat_b"},   wr_sat[1], exp_sat_b);
        check_eq({tag, "_done_n"},  32'(done_cnt), 32'd1);
        check_eq({tag, "_done_cyc"}, 32'(done_cyc), 32'd17);
        check_eq({tag, "_ready_cyc"}, 32'(first_ready), 32'd17);
    endtask

    logic [31:0] sat_exp_a, sat_exp_b, sat_flag;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready",  {31'd0, upd_ready}, 32'd0);
        check_eq("rst_rd_en",  {31'd0, q_rd_en},   32'd0);
        check_eq("rst_wr_en",  {31'd0, q_wr_en},   32'd0);
        check_eq("rst_done",   {31'd0, upd_done},  32'd0);
        check_eq("rst_sat",    {31'd0, sat_evt},   32'd0);
        check_eq("rst_sel",    {31'd0, q_sel},     32'd0);
        check_eq("rst_addr",   32'(q_addr),        32'd0);
        check_eq("rst_wdata",  q_wdata,            32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", {31'd0, upd_ready}, 32'd1);

        // Basic update. A: max(0,2.0,1.0,-tiny)=2.0, gq=1.0, td=2.0 -> 0.5.
        // B (S==Snx, Qcur is one of the next-state entries): max=3.0,
        // gq=1.5, td=-1+1.5-3=-2.5, >>>2=-0.625 -> 3-0.625=2.375=0x0002_6000.
        set_q(0, 7, 0, 32'h0000_0000); set_q(0, 7, 1, 32'h0002_0000);
        set_q(0, 7, 2, 32'h0001_0000); set_q(0, 7, 3, 32'hFFFF_FFFF);
        set_q(0, 5, 2, 32'h0000_0000);
        set_q(1, 9, 0, 32'h0001_0000); set_q(1, 9, 1, 32'h0003_0000);
        set_q(1, 9, 2, 32'hFFFF_0000); set_q(1, 9, 3, 32'h0003_0000);
        run_txn("basic", 16'h8000, 5, 7, 2, 32'h0001_0000, 9, 9, 1, 32'hFFFF_0000,
                32'h0000_8000, 32'h0002_6000, 32'd0, 32'd0);

        // Saturation. A: max must be the signed max 0x7FFF_FFFF (0x8000_0000
        // is the most negative). gq=0x7FFF_7FFF, td=0x8000_7FFE, >>>2 =
        // 0x2000_1FFF, Qnew=0x9FFF_1FFF (positive overflow).
        // B: all -2^31, gq=-0x7FFF_8000, td=-0x7FFF_8000, >>>2=-0x1FFF_E000,
        // Qnew=-0x9FFF_E000 (negative overflow, wraps to 0x6000_2000).
        set_q(0, 2, 0, 32'h7FFF_FFFF); set_q(0, 2, 1, 32'h8000_0000);
        set_q(0, 2, 2, 32'h7FFF_FFFF); set_q(0, 2, 3, 32'h0000_0000);
        set_q(0, 1, 3, 32'h7FFF_0000);
        for (int i = 0; i < 4; i++) set_q(1, 4, i, 32'h8000_0000);
        set_q(1, 3, 0, 32'h8000_0000);
`ifdef QLU_SAT_EN
        sat_exp_a = 32'h7FFF_FFFF; sat_exp_b = 32'h8000_0000; sat_flag = 32'd1;
`else
        sat_exp_a = 32'h9FFF_1FFF; sat_exp_b = 32'h6000_2000; sat_flag = 32'd0;
`endif
        run_txn("sat", 16'hFFFF, 1, 2, 3, 32'h7FFF_FFFF, 3, 4, 0, 32'h8000_0000,
                sat_exp_a, sat_exp_b, sat_flag, sat_flag);

        // Negative values and ties: all next Qs -2.0, gq=0xFFFE_0002.
        // A: R=0, Qcur=0, td=-0x1FFFE, >>>2=-0x8000 -> 0xFFFF_8000.
        // B: R=-0.5, Qcur=-1.0, td=-0x17FFE, >>>2=-0x6000 -> 0xFFFE_A000.
        for (int i = 0; i < 4; i++) begin
            set_q(0, 10, i, 32'hFFFE_0000);
            set_q(1, 14, i, 32'hFFFE_0000);
        end
        set_q(0, 11, 1, 32'h0000_0000);
        set_q(1, 13, 2, 32'hFFFF_0000);
        run_txn("neg", 16'hFFFF, 11, 10, 1, 32'h0000_0000, 13, 14, 2, 32'hFFFF_8000,
                32'hFFFF_8000, 32'hFFFE_A000, 32'd0, 32'd0);

        // learning=0: no memory traffic, done in cycle 1, ready never drops.
        start_txn(1'b0, 16'h8000, 5, 7, 2, 32'h0001_0000, 9, 9, 1, 32'h0001_0000);
        repeat (22) @(negedge clk);
        mon_on = 1'b0;
        $display("txn nolearn: reads %0d/%0d writes %0d/%0d done @%0d",
                 rd_cnt[0], rd_cnt[1], wr_cnt[0], wr_cnt[1], done_cyc);
        check_eq("nolearn_rd",        32'(rd_cnt[0] + rd_cnt[1]), 32'd0);
        check_eq("nolearn_wr",        32'(wr_cnt[0] + wr_cnt[1]), 32'd0);
        check_eq("nolearn_done_n",    32'(done_cnt), 32'd1);
        check_eq("nolearn_done_cyc",  32'(done_cyc), 32'd1);
        check_eq("nolearn_ready_low", 32'(ready_low), 32'd0);

        // Reset during agent A's CALC cycle (cycle 7): the cycle-8 write
        // must never happen.
        start_txn(1'b1, 16'h8000, 5, 7, 2, 32'h0001_0000, 9, 9, 1, 32'h0001_0000);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_wr_en",  {31'd0, q_wr_en},  32'd0);
        check_eq("abort_rd_en",  {31'd0, q_rd_en},  32'd0);
        check_eq("abort_ready",  {31'd0, upd_ready}, 32'd0);
        check_eq("abort_addr",   32'(q_addr),       32'd0);
        check_eq("abort_wdata",  q_wdata,           32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready_after", {31'd0, upd_ready}, 32'd1);
        repeat (15) @(negedge clk);
        mon_on = 1'b0;
        $display("txn abort: reads %0d/%0d writes %0d/%0d done count %0d",
                 rd_cnt[0], rd_cnt[1], wr_cnt[0], wr_cnt[1], done_cnt);
        check_eq("abort_rd_a",   32'(rd_cnt[0]), 32'd5);
        check_eq("abort_rd_b",   32'(rd_cnt[1]), 32'd0);
        check_eq("abort_wr",     32'(wr_cnt[0] + wr_cnt[1]), 32'd0);
        check_eq("abort_done_n", 32'(done_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
